// File: rtl/card_io_pkg.sv
// Shared definitions for the interlock card I/O conditioning: channel map,
// default alarm latch mask and default filter timing for 2 ms sampling.
package card_io_pkg;

   localparam int N_CH_DEF = 16;

   // Field input channel assignment on the card connector
   localparam int CH_I_AN_HIGH     = 0;
   localparam int CH_I_G2_HIGH     = 1;
   localparam int CH_DC_PS         = 2;
   localparam int CH_U_AN_LOW      = 3;
   localparam int CH_CARD_POS      = 4;
   localparam int CH_EMERGENCY     = 5;
   localparam int CH_U_G2_LOW      = 6;
   localparam int CH_G2_PS_ACT     = 7;
   localparam int CH_DRAC_OVERTEMP = 8;
   localparam int CH_DR_AMP        = 9;

   // No channel latches unless the card configuration asks for it
   localparam logic [N_CH_DEF-1:0] DEF_LATCH_MASK = 16'h0000;

   // 1024 clocks per sample tick, 64 ticks of qualification
   localparam int DEF_FILT_LEN = 64;
   localparam int DEF_DIV      = 1024;

   // Integrator width able to hold 0..filt_len inclusive
   function automatic int cnt_width(input int filt_len);
      return $clog2(filt_len + 1);
   endfunction

endpackage

// File: rtl/lpf_channel.sv
// One conditioning channel: 2-flop synchronizer, saturating up/down
// integrator with hysteresis, edge pulses and an optional sticky alarm latch.
module lpf_channel
   import card_io_pkg::*;
#(
   parameter int FILT_LEN = DEF_FILT_LEN,
   parameter bit LATCHING = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic tick,
   input  logic raw,
   input  logic clear_latch,
   output logic filt_out,
   output logic rise_pulse,
   output logic fall_pulse,
   output logic latched_out
);

   localparam int               CNT_W = cnt_width(FILT_LEN);
   localparam logic [CNT_W-1:0] FULL  = CNT_W'(FILT_LEN);

   logic             sync_p0;
   logic             sync_p1;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             filt_nxt;
   logic             sticky;

   // Bring the asynchronous field level into the clock domain
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sync_p0 <= 1'b0;
         sync_p1 <= 1'b0;
      end else begin
         sync_p0 <= raw;
         sync_p1 <= sync_p0;
      end
   end

   // Saturating integrator step and hysteresis decision for this tick
   always_comb begin
      cnt_nxt  = cnt;
      filt_nxt = filt_out;
      if (tick) begin
         if (sync_p1 && (cnt < FULL)) begin
            cnt_nxt = cnt + CNT_W'(1);
         end else if (!sync_p1 && (cnt != '0)) begin
            cnt_nxt = cnt - CNT_W'(1);
         end
      end
      if (cnt_nxt == FULL) begin
         filt_nxt = 1'b1;
      end else if (cnt_nxt == '0) begin
         filt_nxt = 1'b0;
      end
   end

   // Integrator state, filtered level and edge pulses coincident with it
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt        <= '0;
         filt_out   <= 1'b0;
         rise_pulse <= 1'b0;
         fall_pulse <= 1'b0;
      end else begin
         cnt        <= cnt_nxt;
         filt_out   <= filt_nxt;
         rise_pulse <= filt_nxt & ~filt_out;
         fall_pulse <= ~filt_nxt & filt_out;
      end
   end

   // Sticky alarm: set by a rise, cleared by operator only once the level is gone
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sticky <= 1'b0;
      end else begin
         sticky <= LATCHING & (rise_pulse | (sticky & ~(clear_latch & ~filt_out)));
      end
   end

   assign latched_out = filt_out | sticky;

endmodule

// File: rtl/input_lpf_bank.sv
// Input conditioning bank: shared sample-tick prescaler, N_CH filtered
// channels and a registered summary of all latching alarm channels.
module input_lpf_bank
   import card_io_pkg::*;
#(
   parameter int              N_CH       = N_CH_DEF,
   parameter int              FILT_LEN   = DEF_FILT_LEN,
   parameter int              DIV        = DEF_DIV,
   parameter logic [N_CH-1:0] LATCH_MASK = N_CH'(DEF_LATCH_MASK)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            en,
   input  logic [N_CH-1:0] raw_in,
   input  logic            clear_latch,
   output logic [N_CH-1:0] filt_out,
   output logic [N_CH-1:0] rise_pulse,
   output logic [N_CH-1:0] fall_pulse,
   output logic [N_CH-1:0] latched_out,
   output logic            any_alarm,
   output logic            tick
);

   localparam int               PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [PRE_W-1:0] LAST  = PRE_W'(DIV - 1);

   logic [PRE_W-1:0] pre_cnt;
   logic [PRE_W-1:0] pre_nxt;

   // Next prescaler count, wrapping after DIV-1
   always_comb begin
      pre_nxt = (pre_cnt == LAST) ? '0 : pre_cnt + PRE_W'(1);
   end

   // Prescaler and tick strobe; tick is high while the count sits at DIV-1.
   // Integrators step on the registered tick, so a tick already issued when
   // en drops is still consumed and pausing shifts qualification exactly.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pre_cnt <= '0;
         tick    <= 1'b0;
      end else if (en) begin
         pre_cnt <= pre_nxt;
         tick    <= (pre_nxt == LAST);
      end else begin
         tick    <= 1'b0;
      end
   end

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      lpf_channel #(
         .FILT_LEN (FILT_LEN),
         .LATCHING (LATCH_MASK[i])
      ) u_ch (
         .clk         (clk),
         .reset       (reset),
         .tick        (tick),
         .raw         (raw_in[i]),
         .clear_latch (clear_latch),
         .filt_out    (filt_out[i]),
         .rise_pulse  (rise_pulse[i]),
         .fall_pulse  (fall_pulse[i]),
         .latched_out (latched_out[i])
      );
   end

   // Summary alarm over latching channels, one cycle behind latched_out
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         any_alarm <= 1'b0;
      end else begin
         any_alarm <= |(latched_out & LATCH_MASK);
      end
   end

endmodule

// File: tb/tb_input_lpf_bank.sv
// Directed bench for input_lpf_bank: one instance with DIV=1/FILT_LEN=4 and
// channel 0 latching, one with DIV=4/FILT_LEN=3 for prescaler and enable.
module tb_input_lpf_bank;

   logic        clk = 1'b0;
   logic        reset;
   logic        en_a, en_b;
   logic [15:0] raw_a, raw_b;
   logic        clr_a, clr_b;
   logic [15:0] filt_a, rise_a, fall_a, lat_a;
   logic [15:0] filt_b, rise_b, fall_b, lat_b;
   logic        any_a, any_b, tick_a, tick_b;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   input_lpf_bank #(
      .N_CH(16), .FILT_LEN(4), .DIV(1), .LATCH_MASK(16'h0001)
   ) dut_a (
      .clk(clk), .reset(reset), .en(en_a), .raw_in(raw_a),
      .clear_latch(clr_a), .filt_out(filt_a), .rise_pulse(rise_a),
      .fall_pulse(fall_a), .latched_out(lat_a), .any_alarm(any_a),
      .tick(tick_a)
   );

   input_lpf_bank #(
      .N_CH(16), .FILT_LEN(3), .DIV(4), .LATCH_MASK(16'h0000)
   ) dut_b (
      .clk(clk), .reset(reset), .en(en_b), .raw_in(raw_b),
      .clear_latch(clr_b), .filt_out(filt_b), .rise_pulse(rise_b),
      .fall_pulse(fall_b), .latched_out(lat_b), .any_alarm(any_b),
      .tick(tick_b)
   );

   task automatic chk1(input string tag, input logic obs, input logic exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %b expected %b", tag, obs, exp);
      end
   endtask

   task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Advance until dut_b shows tick (bounded); the next edge is a stepping edge
   task automatic align_tick_b(input string tag);
      logic found;
      found = 1'b0;
      for (int i = 0; i < 8 && !found; i++) begin
         step(1);
         if (tick_b) found = 1'b1;
      end
      chk1(tag, found, 1'b1);
   endtask

   initial begin
      logic quiet;
      logic gap_ok;
      logic gone;

      reset = 1'b0; en_a = 1'b1; en_b = 1'b1;
      raw_a = '0; raw_b = '0; clr_a = 1'b0; clr_b = 1'b0;

      // reset state
      #2;
      chk16("rst_filt", filt_a, 16'h0000);
      chk16("rst_latched", lat_a, 16'h0000);
      chk1("rst_alarm", any_a, 1'b0);
      chk1("rst_tick", tick_a, 1'b0);
      step(2);
      reset = 1'b1;
      step(3);
      chk1("tick_div1", tick_a, 1'b1);

      // clean rising step on latching channel 0
      raw_a[0] = 1'b1;
      step(5);
      chk1("rise_early", filt_a[0], 1'b0);
      step(1);
      chk1("rise_filt", filt_a[0], 1'b1);
      chk1("rise_pulse", rise_a[0], 1'b1);
      chk1("rise_latched", lat_a[0], 1'b1);
      step(1);
      chk1("rise_pulse_once", rise_a[0], 1'b0);
      chk1("alarm_set", any_a, 1'b1);

      // clear while alarm is active is ignored and not remembered
      clr_a = 1'b1;
      step(1);
      clr_a = 1'b0;
      chk1("clr_active", lat_a[0], 1'b1);

      // falling step
      raw_a[0] = 1'b0;
      step(5);
      chk1("fall_early", filt_a[0], 1'b1);
      step(1);
      chk1("fall_filt", filt_a[0], 1'b0);
      chk1("fall_pulse", fall_a[0], 1'b1);
      chk1("fall_no_rise", rise_a[0], 1'b0);
      chk1("sticky_hold", lat_a[0], 1'b1);
      step(1);
      chk1("fall_pulse_once", fall_a[0], 1'b0);
      chk1("alarm_hold", any_a, 1'b1);

      // operator clear after the fall
      clr_a = 1'b1;
      step(1);
      clr_a = 1'b0;
      chk1("clr_latched", lat_a[0], 1'b0);
      chk1("clr_alarm_lag", any_a, 1'b1);
      step(1);
      chk1("clr_alarm", any_a, 1'b0);

      // 3-cycle glitch on unmasked channel 1 never qualifies
      quiet = 1'b1;
      raw_a[1] = 1'b1;
      for (int i = 0; i < 12; i++) begin
         if (i == 3) raw_a[1] = 1'b0;
         step(1);
         if (filt_a[1] || rise_a[1] || fall_a[1] || lat_a[1]) quiet = 1'b0;
      end
      chk1("glitch_quiet", quiet, 1'b1);

      // integrator drained back to 0: full qualification time again
      raw_a[1] = 1'b1;
      step(5);
      chk1("requal_early", filt_a[1], 1'b0);
      step(1);
      chk1("requal_filt", filt_a[1], 1'b1);
      chk1("requal_pulse", rise_a[1], 1'b1);
      step(1);
      chk1("unmasked_no_alarm", any_a, 1'b0);
      raw_a[1] = 1'b0;
      step(6);
      chk1("unmasked_fall", fall_a[1], 1'b1);
      chk1("unmasked_no_sticky", lat_a[1], 1'b0);

      // rise pulse coinciding with clear: set wins
      raw_a[0] = 1'b1;
      step(6);
      chk1("setwin_rise", rise_a[0], 1'b1);
      clr_a = 1'b1;
      step(1);
      clr_a = 1'b0;
      raw_a[0] = 1'b0;
      step(6);
      chk1("setwin_fell", filt_a[0], 1'b0);
      chk1("setwin_sticky", lat_a[0], 1'b1);
      clr_a = 1'b1;
      step(1);
      clr_a = 1'b0;
      chk1("setwin_cleared", lat_a[0], 1'b0);
      step(1);

      // asynchronous reset in the middle of qualification
      raw_a[2] = 1'b1;
      step(6);
      chk1("pre_rst_ch2", filt_a[2], 1'b1);
      raw_a[0] = 1'b1;
      step(4);
      #2 reset = 1'b0;
      #1;
      chk16("async_filt", filt_a, 16'h0000);
      chk16("async_latched", lat_a, 16'h0000);
      chk1("async_tick", tick_a, 1'b0);
      step(2);
      reset = 1'b1;
      step(5);
      chk16("post_rst_early", filt_a, 16'h0000);
      step(1);
      chk16("post_rst_requal", filt_a, 16'h0005);
      raw_a = '0;

      // DIV=4 prescaler: one tick every 4th cycle
      align_tick_b("tick_b_found");
      gap_ok = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step(1);
         if (tick_b) gap_ok = 1'b0;
      end
      chk1("tick_b_gap", gap_ok, 1'b1);
      step(1);
      chk1("tick_b_period", tick_b, 1'b1);

      // FILT_LEN=3 qualification with ticks every 4 cycles: 13 edges
      raw_b[0] = 1'b1;
      step(12);
      chk1("b_qual_early", filt_b[0], 1'b0);
      step(1);
      chk1("b_qual", filt_b[0], 1'b1);

      raw_b[0] = 1'b0;
      gone = 1'b0;
      for (int i = 0; i < 40 && !gone; i++) begin
         step(1);
         if (!filt_b[0]) gone = 1'b1;
      end
      chk1("b_drain", gone, 1'b1);

      // same qualification with en dropped for 10 cycles: 23 edges
      align_tick_b("tick_b_realign");
      raw_b[0] = 1'b1;
      step(6);
      en_b = 1'b0;
      step(10);
      chk1("b_en_tick_off", tick_b, 1'b0);
      en_b = 1'b1;
      step(6);
      chk1("b_pause_early", filt_b[0], 1'b0);
      step(1);
      chk1("b_pause_qual", filt_b[0], 1'b1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
